req_arbiter_8: RTL and testbench

Sequential arbiter that shares one resource among eight requesters. It selects a winner through the team's 8-to-3 priority-encoding scheme and issues a registered one-hot grant with its index. The grant is held until the owner releases it or a hold timeout forces release. It sits in front of any shared datapath (bus, memory port, encoder pipeline) that accepts one master at a time.

---
 rtl/req_arbiter_8.sv | 133 +++++++++++++
 tb/tb_req_arbiter_8.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/req_arbiter_8.sv
// Eight-way resource arbiter with registered one-hot grant, hold timeout and preemption.
// Define ARB_ROUND_ROBIN_EN for rotating priority; otherwise the highest index wins.
module req_arbiter_8 #(
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned HOLD_W   = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] gnt_id,
   output logic       gnt_valid,
   output logic       preempt
);

   typedef enum logic [0:0] {StIdle, StGrant} state_t;

   localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'(MAX_HOLD - 1);
   localparam logic [HOLD_W-1:0] HoldMax  = {HOLD_W{1'b1}};
   localparam bit                TimeoutOn = (MAX_HOLD != 0);

   state_t            state;
   logic [HOLD_W-1:0] hold_cnt;
   logic [7:0]        mask;

   logic [7:0] cand;
   logic [2:0] win;
   logic       owner_req;
   logic       competitor;
   logic       timeout;

   // A preempted owner only yields when someone else is actually asking.
   always_comb begin
      cand = req & ~mask;
      if (cand == 8'h00) begin
         cand = req;
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   logic [2:0]  last_id;
   logic [2:0]  start;
   logic [15:0] dbl;
   logic [7:0]  rot;
   logic [2:0]  off;

   always_comb begin
      start = last_id + 3'd1;
      dbl   = {cand, cand} >> start;
      rot   = dbl[7:0];
      off   = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         if (rot[k]) begin
            off = 3'(k);
         end
      end
      win = start + off;
   end
`else
   // 8-to-3 priority encoder, highest index dominates.
   always_comb begin
      win = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (cand[i]) begin
            win = 3'(i);
         end
      end
   end
`endif

   assign owner_req  = |(req & gnt);
   assign competitor = |(req & ~gnt);
   assign timeout    = TimeoutOn && (hold_cnt == HoldLast) && competitor;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= StIdle;
         gnt       <= 8'h00;
         gnt_id    <= 3'd0;
         gnt_valid <= 1'b0;
         preempt   <= 1'b0;
         hold_cnt  <= '0;
         mask      <= 8'h00;
`ifdef ARB_ROUND_ROBIN_EN
         last_id   <= 3'd7;
`endif
      end else begin
         unique case (state)
            StIdle: begin
               preempt <= 1'b0;
               if (req != 8'h00) begin
                  gnt       <= 8'b1 << win;
                  gnt_id    <= win;
                  gnt_valid <= 1'b1;
                  hold_cnt  <= '0;
                  mask      <= 8'h00;
                  state     <= StGrant;
`ifdef ARB_ROUND_ROBIN_EN
                  last_id   <= win;
`endif
               end
            end
            StGrant: begin
               if (!owner_req) begin
                  gnt       <= 8'h00;
                  gnt_id    <= 3'd0;
                  gnt_valid <= 1'b0;
                  preempt   <= 1'b0;
                  hold_cnt  <= '0;
                  state     <= StIdle;
               end else if (timeout) begin
                  mask      <= gnt;
                  gnt       <= 8'h00;
                  gnt_id    <= 3'd0;
                  gnt_valid <= 1'b0;
                  preempt   <= 1'b1;
                  hold_cnt  <= '0;
                  state     <= StIdle;
               end else begin
                  preempt <= 1'b0;
                  if (hold_cnt != HoldMax) begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_req_arbiter_8.sv
// Bench for req_arbiter_8: directed scenarios plus random requests against a behavioural model.
module tb_req_arbiter_8;

   localparam int unsigned MaxHold = 4;
   localparam int unsigned HoldW   = 8;
   localparam int          CntSat  = (1 << HoldW) - 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] req = 8'h00;
   logic [7:0] gnt;
   logic [2:0] gnt_id;
   logic       gnt_valid;
   logic       preempt;

   int passed = 0;
   int total  = 0;

   // Model state: owner index (-1 none), cycles held, masked index (-1 none), last winner.
   int m_owner, m_held, m_mask, m_last;
   bit m_pre;

   req_arbiter_8 #(.MAX_HOLD(MaxHold), .HOLD_W(HoldW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .preempt   (preempt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic void model_reset();
      m_owner = -1;
      m_held  = 0;
      m_mask  = -1;
      m_last  = 7;
      m_pre   = 1'b0;
   endfunction

   function automatic int pick(input logic [7:0] c, input int last);
`ifdef ARB_ROUND_ROBIN_EN
      for (int k = 1; k <= 8; k++) begin
         if (c[(last + k) % 8]) return (last + k) % 8;
      end
`else
      for (int i = 7; i >= 0; i--) begin
         if (c[i]) return i;
      end
`endif
      return -1;
   endfunction

   function automatic void model_step(input logic [7:0] r);
      logic [7:0] c;
      int         w;
      if (m_owner < 0) begin
         m_pre = 1'b0;
         if (r != 8'h00) begin
            c = r;
            if (m_mask >= 0 && (r & ~(8'h01 << m_mask)) != 8'h00) c = r & ~(8'h01 << m_mask);
            w       = pick(c, m_last);
            m_owner = w;
            m_last  = w;
            m_held  = 0;
            m_mask  = -1;
         end
      end else if (!r[m_owner]) begin
         m_owner = -1;
         m_pre   = 1'b0;
      end else if (MaxHold != 0 && m_held == int'(MaxHold) - 1 &&
                   (r & ~(8'h01 << m_owner)) != 8'h00) begin
         m_mask  = m_owner;
         m_owner = -1;
         m_pre   = 1'b1;
      end else begin
         m_pre  = 1'b0;
         m_held = (m_held < CntSat) ? m_held + 1 : CntSat;
      end
   endfunction

   task automatic compare_all(input string tag);
      logic [7:0] eg;
      logic [2:0] ei;
      eg = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
      ei = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
      check({tag, ".gnt"}, 32'(gnt), 32'(eg));
      check({tag, ".gnt_id"}, 32'(gnt_id), 32'(ei));
      check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(m_owner >= 0));
      check({tag, ".preempt"}, 32'(preempt), 32'(m_pre));
   endtask

   task automatic cyc(input string tag);
      @(posedge clk);
      #1;
      if (rst_n) model_step(req);
      compare_all(tag);
   endtask

   initial begin
      int n80, npre, seen02, id_seq;
      model_reset();

      // Reset with all requests high, then idle.
      req = 8'hFF;
      for (int i = 0; i < 3; i++) cyc("rst");
      rst_n = 1'b1;
      req   = 8'h00;
      for (int i = 0; i < 3; i++) cyc("idle");

      // Priority selection and release with dead cycle.
      req = 8'b0010_0110;
      cyc("pri1");
`ifndef ARB_ROUND_ROBIN_EN
      check("pri_gnt20", 32'(gnt), 32'h20);
      check("pri_id5", 32'(gnt_id), 32'd5);
`endif
      req = 8'b0000_0110;
      cyc("pri2");
      check("pri_dead", 32'(gnt), 32'h00);
      cyc("pri3");
`ifndef ARB_ROUND_ROBIN_EN
      check("pri_gnt04", 32'(gnt), 32'h04);
`endif
      req = 8'h00;
      cyc("pri4");
      cyc("pri5");

      // Timeout with a continuous competitor.
      req    = 8'h82;
      n80    = 0;
      npre   = 0;
      seen02 = 0;
      for (int i = 0; i < 8; i++) begin
         cyc("to");
         if (gnt == 8'h80) n80++;
         if (preempt) npre++;
         if (gnt == 8'h02) seen02++;
      end
`ifndef ARB_ROUND_ROBIN_EN
      check("to_hold_cycles", 32'(n80), 32'd4);
      check("to_preempt_cnt", 32'(npre), 32'd1);
      check("to_masked_win", 32'(seen02), 32'd3);
`endif
      req = 8'h80;
      cyc("to_rel");
      cyc("to_regain");
`ifndef ARB_ROUND_ROBIN_EN
      check("to_regain80", 32'(gnt), 32'h80);
`endif
      req = 8'h00;
      cyc("to_end");
      cyc("to_end2");

      // Lone owner keeps the grant past the timeout.
      req  = 8'h08;
      cyc("lone0");
      n80  = 0;
      npre = 0;
      for (int i = 0; i < 40; i++) begin
         cyc("lone");
         if (gnt == 8'h08) n80++;
         if (preempt) npre++;
      end
      check("lone_cycles", 32'(n80), 32'd40);
      check("lone_preempt", 32'(npre), 32'd0);
      req = 8'h00;
      cyc("lone_end");
      cyc("lone_end2");

`ifdef ARB_ROUND_ROBIN_EN
      // Rotation: each owner drops its request for one cycle.
      req = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         cyc("rr_g");
         id_seq = int'(gnt_id);
         check("rr_seq", 32'(id_seq), 32'(k % 8));
         req = 8'hFF & ~(8'h01 << id_seq);
         cyc("rr_r");
         req = 8'hFF;
      end
      req = 8'h00;
      cyc("rr_end");
      cyc("rr_end2");
`endif

      // Asynchronous reset in the middle of a grant.
      req = 8'h10;
      cyc("mid0");
      check("mid_gnt10", 32'(gnt), 32'h10);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("mid_async_gnt", 32'(gnt), 32'h00);
      check("mid_async_valid", 32'(gnt_valid), 32'd0);
      check("mid_async_id", 32'(gnt_id), 32'd0);
      cyc("mid_held");
      rst_n = 1'b1;
      cyc("mid_back");
      check("mid_regrant", 32'(gnt), 32'h10);

      // Random sparse request toggling.
      for (int i = 0; i < 3000; i++) begin
         req = req ^ 8'($urandom & $urandom & $urandom);
         if ($urandom_range(0, 15) == 0) req = 8'($urandom);
         cyc("rnd");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
